add_serial: RTL



---
 rtl/add_serial.sv | 106 ++++++++++
 1 files changed

// File: rtl/add_serial.sv
// add_serial: multi-cycle N-bit adder that sums K bits per clock, carrying between chunks in a register.
// Operand regs shift right each chunk; the sum shifts in from the top so it is aligned after NC chunks.
module add_serial #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co,
  output logic         busy
);
  localparam int NC = N / K;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  s_q, s_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [K:0]    chunk_sum;
  logic [N-1:0]  chunk_top;

  assign chunk_sum = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
  assign chunk_top = N'(chunk_sum[K-1:0]) << (N - K);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready and out_valid decode state_q only, so neither depends on any input.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign co        = co_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> K;
        b_d     = b_q >> K;
        s_d     = (s_q >> K) | chunk_top;
        carry_d = chunk_sum[K];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NC - 1)) begin
          co_d    = chunk_sum[K];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
    end
  end
endmodule
